// File: rtl/dcpu16_pkg.sv
// Shared opcode, operand-code and phase definitions for the DCPU16 sequencer.
package dcpu16_pkg;

  localparam logic [3:0] OP_NB  = 4'h0;
  localparam logic [3:0] OP_SET = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_DIV = 4'h5;
  localparam logic [3:0] OP_MOD = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_BOR = 4'hA;
  localparam logic [3:0] OP_XOR = 4'hB;
  localparam logic [3:0] OP_IFE = 4'hC;
  localparam logic [3:0] OP_IFN = 4'hD;
  localparam logic [3:0] OP_IFG = 4'hE;
  localparam logic [3:0] OP_IFB = 4'hF;

  localparam logic [5:0] NB_JSR = 6'h01;

  localparam logic [5:0] OPR_NWREG_LO = 6'h10;
  localparam logic [5:0] OPR_NWREG_HI = 6'h17;
  localparam logic [5:0] OPR_PC       = 6'h1C;
  localparam logic [5:0] OPR_NW       = 6'h1E;
  localparam logic [5:0] OPR_LIT      = 6'h1F;

  typedef enum logic [1:0] {
    PHA_EX = 2'd0,
    PHA_FE = 2'd1,
    PHA_NA = 2'd2,
    PHA_NB = 2'd3
  } pha_e;

  function automatic logic is_wb_op(input logic [3:0] op);
    return (op >= OP_SET) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/dcpu16_nwdec.sv
// Flags operand codes that carry a trailing next-word in the instruction stream.
module dcpu16_nwdec
  import dcpu16_pkg::*;
(
  input  logic [5:0] code,
  output logic       need_nw
);

  always_comb begin
    need_nw = ((code >= OPR_NWREG_LO) && (code <= OPR_NWREG_HI)) ||
              (code == OPR_NW) || (code == OPR_LIT);
  end

endmodule

// File: rtl/dcpu16_seq.sv
// DCPU16 instruction sequencer: owns PC, fetches instruction and next-words,
// drives ALU opcode/phase and handles IF-skip, writeback and PC loads.
module dcpu16_seq
  import dcpu16_pkg::*;
#(
  parameter logic [15:0] RST_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] f_adr,
  output logic        f_stb,
  input  logic        f_ack,
  input  logic [15:0] f_dti,
  output logic [3:0]  opc,
  output logic [1:0]  pha,
  output logic        ena,
  output logic [5:0]  ea,
  output logic [5:0]  eb,
  output logic [15:0] nwa,
  output logic [15:0] nwb,
  input  logic        CC,
  input  logic [15:0] rwd,
  output logic        rwe,
  output logic [5:0]  rwa,
  output logic        psh,
  output logic [15:0] regPC
);

  pha_e        pha_q, pha_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] nwa_q, nwa_d;
  logic [15:0] nwb_q, nwb_d;
  logic        skip_q, skip_d;
  logic        wb_pend_q, wb_pend_d;
  logic        wb_en_q, wb_en_d;
  logic        jsr_pend_q, jsr_pend_d;

  logic [3:0]  op;
  logic [5:0]  fld_a, fld_b;
  logic        basic, is_jsr;
  logic        need_a, need_b;

  always_comb begin
    op     = ir_q[3:0];
    fld_a  = ir_q[9:4];
    fld_b  = ir_q[15:10];
    basic  = (op != OP_NB);
    is_jsr = !basic && (fld_a == NB_JSR);
    ea     = basic ? fld_a : fld_b;
    eb     = basic ? fld_b : '0;
    if (skip_q)      opc = OP_SET;
    else if (!basic) opc = is_jsr ? 4'h0 : OP_SET;
    else             opc = op;
  end

  dcpu16_nwdec u_nwdec_a (.code(ea), .need_nw(need_a));
  dcpu16_nwdec u_nwdec_b (.code(eb), .need_nw(need_b));

  always_comb begin
    pha_d      = pha_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    nwa_d      = nwa_q;
    nwb_d      = nwb_q;
    skip_d     = skip_q;
    wb_pend_d  = wb_pend_q;
    wb_en_d    = wb_en_q;
    jsr_pend_d = jsr_pend_q;
    f_stb      = 1'b0;
    ena        = 1'b0;
    rwe        = 1'b0;
    psh        = 1'b0;

    case (pha_q)
      PHA_FE: begin
        // The cycle after execute is spent on writeback/PC load; fetch waits.
        if (wb_pend_q) begin
          if (jsr_pend_q) begin
            psh  = 1'b1;
            pc_d = rwd;
          end else if (wb_en_q) begin
            rwe = 1'b1;
            if (ea == OPR_PC) pc_d = rwd;
          end
          wb_pend_d  = 1'b0;
          jsr_pend_d = 1'b0;
        end else begin
          f_stb = 1'b1;
          if (f_ack) begin
            ir_d   = f_dti;
            pc_d   = pc_q + 16'd1;
            skip_d = ~CC;
            pha_d  = PHA_NA;
          end
        end
      end
      PHA_NA: begin
        if (need_a) begin
          f_stb = 1'b1;
          if (f_ack) begin
            nwa_d = f_dti;
            pc_d  = pc_q + 16'd1;
            pha_d = PHA_NB;
          end
        end else begin
          pha_d = PHA_NB;
        end
      end
      PHA_NB: begin
        if (need_b) begin
          f_stb = 1'b1;
          if (f_ack) begin
            nwb_d = f_dti;
            pc_d  = pc_q + 16'd1;
            pha_d = PHA_EX;
          end
        end else begin
          pha_d = PHA_EX;
        end
      end
      PHA_EX: begin
        ena        = 1'b1;
        wb_en_d    = ~skip_q & basic & is_wb_op(op);
        jsr_pend_d = ~skip_q & is_jsr;
        wb_pend_d  = 1'b1;
        pha_d      = PHA_FE;
      end
    endcase

    if (rst) begin
      f_stb = 1'b0;
      ena   = 1'b0;
      rwe   = 1'b0;
      psh   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pha_q      <= PHA_FE;
      pc_q       <= RST_PC;
      ir_q       <= '0;
      nwa_q      <= '0;
      nwb_q      <= '0;
      skip_q     <= 1'b0;
      wb_pend_q  <= 1'b0;
      wb_en_q    <= 1'b0;
      jsr_pend_q <= 1'b0;
    end else begin
      pha_q      <= pha_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      nwa_q      <= nwa_d;
      nwb_q      <= nwb_d;
      skip_q     <= skip_d;
      wb_pend_q  <= wb_pend_d;
      wb_en_q    <= wb_en_d;
      jsr_pend_q <= jsr_pend_d;
    end
  end

  assign f_adr = pc_q;
  assign regPC = pc_q;
  assign pha   = pha_q;
  assign nwa   = nwa_q;
  assign nwb   = nwb_q;
  assign rwa   = ea;

endmodule

// File: tb/tb_dcpu16_seq.sv
// Random-program bench for dcpu16_seq: an instruction-level model builds the
// expected event stream; a monitor matches DUT strobes against it in order.
module tb_dcpu16_seq;

  localparam logic [15:0] RST_PC = 16'hFFFA;
  localparam int unsigned NI     = 250;

  localparam int unsigned EV_FETCH = 0;
  localparam int unsigned EV_EXEC  = 1;
  localparam int unsigned EV_WB    = 2;
  localparam int unsigned EV_PSH   = 3;

  logic        clk;
  logic        rst;
  logic [15:0] f_adr;
  logic        f_stb;
  logic        f_ack;
  logic [15:0] f_dti;
  logic [3:0]  opc;
  logic [1:0]  pha;
  logic        ena;
  logic [5:0]  ea, eb;
  logic [15:0] nwa, nwb;
  logic        CC;
  logic [15:0] rwd;
  logic        rwe;
  logic [5:0]  rwa;
  logic        psh;
  logic [15:0] regPC;

  typedef struct {
    int unsigned kind;
    logic [15:0] adr;
    logic [3:0]  opc;
    logic [5:0]  ea;
    logic [5:0]  eb;
    logic [15:0] nwa;
    logic [15:0] nwb;
    bit          cna;
    bit          cnb;
  } ev_t;

  typedef struct {
    logic [15:0] rwd;
    bit          cc;
  } slot_t;

  logic [15:0] mem [0:65535];
  ev_t         evq[$];
  slot_t       slots[$];
  int          slot_idx;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  bit          mon_on = 0;
  bit          stub_on = 0;
  int unsigned ack_mode = 0;

  dcpu16_seq #(.RST_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .f_adr(f_adr), .f_stb(f_stb), .f_ack(f_ack),
    .f_dti(f_dti), .opc(opc), .pha(pha), .ena(ena), .ea(ea), .eb(eb),
    .nwa(nwa), .nwb(nwb), .CC(CC), .rwd(rwd), .rwe(rwe), .rwa(rwa),
    .psh(psh), .regPC(regPC)
  );

  assign f_dti = mem[f_adr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic expect_kind(input int unsigned k, input string name, output bit ok);
    ok = 1'b0;
    if (evq.size() == 0) begin
      n_total++;
      $display("FAIL %s: got strobe, expected no further events", name);
    end else if (evq[0].kind != k) begin
      n_total++;
      $display("FAIL %s: got event kind %0d, expected kind %0d", name, k, evq[0].kind);
    end else begin
      ok = 1'b1;
    end
  endtask

  function automatic bit need_nw(input logic [5:0] c);
    return ((c >= 6'h10) && (c <= 6'h17)) || (c == 6'h1E) || (c == 6'h1F);
  endfunction

  function automatic logic [5:0] rand_code(input bit allow_pc);
    logic [5:0] c;
    c = 6'($urandom % 64);
    while (!allow_pc && c == 6'h1C) c = 6'($urandom % 64);
    return c;
  endfunction

  task automatic push_ev(input int unsigned k, input logic [15:0] adr);
    ev_t e;
    e = '{kind: k, adr: adr, opc: 4'h0, ea: 6'h0, eb: 6'h0, nwa: 16'h0, nwb: 16'h0, cna: 1'b0, cnb: 1'b0};
    evq.push_back(e);
  endtask

  // Instruction-level model: lays the program into memory while walking its
  // control flow, emitting the strobes each instruction must produce.
  task automatic gen_program();
    logic [15:0] pc;
    int unsigned region, rwords, jumps;
    bit skip;
    pc = RST_PC; region = 0; rwords = 0; jumps = 0; skip = 1'b0;
    for (int n = 0; n < int'(NI); n++) begin
      int unsigned kind, r, len;
      logic [3:0]  op;
      logic [5:0]  fa, fb, xa, xb, rwa_e;
      logic [15:0] ir, wa, wb, tgt, rv;
      bit          nbasic, isjsr, na, nb, cc;
      ev_t         e;
      r = $urandom % 100;
      if (rwords >= 32'h300)            kind = 1;
      else if (n < 8 || r < 70)         kind = 0;
      else if (r < 80 && jumps < 50)    kind = 1;
      else if (r < 90 && jumps < 50)    kind = 2;
      else                              kind = 3;
      case (kind)
        0: begin op = 4'(1 + $urandom % 15); fa = rand_code(1'b0); fb = rand_code(1'b1); end
        1: begin op = 4'(1 + $urandom % 11); fa = 6'h1C; fb = 6'h1F; end
        2: begin op = 4'h0; fa = 6'h01; fb = ($urandom % 2 == 0) ? 6'h1F : rand_code(1'b1); end
        default: begin
          op = 4'h0; fa = 6'($urandom % 64);
          if (fa == 6'h01) fa = 6'h00;
          fb = rand_code(1'b1);
        end
      endcase
      ir     = {fb, fa, op};
      nbasic = (op == 4'h0);
      isjsr  = nbasic && (fa == 6'h01);
      xa     = nbasic ? fb : fa;
      xb     = nbasic ? 6'h00 : fb;
      na     = need_nw(xa);
      nb     = need_nw(xb);
      tgt    = RST_PC + 16'((region + 1) * 1024 + $urandom % 256);
      wa     = 16'($urandom);
      wb     = 16'($urandom);
      if (kind == 2 && xa == 6'h1F) wa = tgt;
      if (kind == 1) wb = tgt;

      mem[pc] = ir; push_ev(EV_FETCH, pc); len = 1;
      if (na) begin mem[pc + 16'(len)] = wa; push_ev(EV_FETCH, pc + 16'(len)); len++; end
      if (nb) begin mem[pc + 16'(len)] = wb; push_ev(EV_FETCH, pc + 16'(len)); len++; end

      e = '{kind: EV_EXEC, adr: 16'h0, opc: 4'h0, ea: xa, eb: xb, nwa: wa, nwb: wb, cna: na, cnb: nb};
      if (skip)        e.opc = 4'h1;
      else if (isjsr)  e.opc = 4'h0;
      else if (nbasic) e.opc = 4'h1;
      else             e.opc = op;
      evq.push_back(e);

      rv = 16'($urandom);
      cc = 1'b1;
      if (!skip) begin
        if (kind == 1 || kind == 2) rv = tgt;
        if (!nbasic && op <= 4'hB) begin
          rwa_e = xa;
          e = '{kind: EV_WB, adr: 16'h0, opc: 4'h0, ea: rwa_e, eb: 6'h0, nwa: 16'h0, nwb: 16'h0, cna: 1'b0, cnb: 1'b0};
          evq.push_back(e);
        end
        if (!nbasic && op >= 4'hC) cc = bit'($urandom % 2);
        if (isjsr) push_ev(EV_PSH, pc + 16'(len));
      end
      slots.push_back('{rwd: rv, cc: cc});

      if (!skip && (kind == 1 || kind == 2)) begin
        pc = tgt; region++; jumps++; rwords = 0;
      end else begin
        pc = pc + 16'(len); rwords += len;
      end
      skip = !cc;
    end
  endtask

  // ALU/memory stub: supplies rwd/CC per executed instruction and fetch acks.
  initial begin
    bit e;
    CC = 1'b1; rwd = '0; f_ack = 1'b0; slot_idx = 0;
    forever begin
      @(negedge clk);
      e = ena && stub_on;
      @(posedge clk);
      #1;
      if (e && slot_idx < slots.size()) begin
        rwd = slots[slot_idx].rwd;
        CC  = slots[slot_idx].cc;
        slot_idx++;
      end
      case (ack_mode)
        0:       f_ack = 1'b0;
        1:       f_ack = 1'b1;
        default: f_ack = ($urandom % 4) != 0;
      endcase
    end
  end

  initial begin
    ev_t e;
    bit  ok;
    forever begin
      @(negedge clk);
      if (mon_on && !rst) begin
        if (rwe) begin
          expect_kind(EV_WB, "rwe", ok);
          if (ok) begin e = evq.pop_front(); chk("rwa", 16'(rwa), 16'(e.ea)); end
        end
        if (psh) begin
          expect_kind(EV_PSH, "psh", ok);
          if (ok) begin e = evq.pop_front(); chk("psh_pc", regPC, e.adr); end
        end
        if (ena) begin
          expect_kind(EV_EXEC, "ena", ok);
          if (ok) begin
            e = evq.pop_front();
            chk("opc", 16'(opc), 16'(e.opc));
            chk("ea", 16'(ea), 16'(e.ea));
            chk("eb", 16'(eb), 16'(e.eb));
            if (e.cna) chk("nwa", nwa, e.nwa);
            if (e.cnb) chk("nwb", nwb, e.nwb);
          end
        end
        if (f_stb && f_ack) begin
          expect_kind(EV_FETCH, "fetch", ok);
          if (ok) begin e = evq.pop_front(); chk("f_adr", f_adr, e.adr); end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    int unsigned cyc;
    rst = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[RST_PC]         = 16'h7C01;
    mem[RST_PC + 16'd1] = 16'h1234;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pha", 16'(pha), 16'd1);
    chk("rst_pc", regPC, RST_PC);
    chk("rst_fadr", f_adr, RST_PC);
    chk("rst_fstb", 16'(f_stb), 16'd0);
    chk("rst_ena", 16'(ena), 16'd0);
    chk("rst_rwe", 16'(rwe), 16'd0);
    chk("rst_psh", 16'(psh), 16'd0);

    // Run SET A,nw until the b next-word fetch is pending, then reset mid-fetch.
    rst = 1'b0;
    ack_mode = 1;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (pha == 2'd3 && f_stb) found = 1'b1;
    end
    chk("reach_pha3", 16'(found), 16'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_pha", 16'(pha), 16'd1);
    chk("midrst_pc", regPC, RST_PC);
    chk("midrst_fstb", 16'(f_stb), 16'd0);
    chk("midrst_eb", 16'(eb), 16'd0);
    @(posedge clk);
    #1;
    chk("midrst_fstb2", 16'(f_stb), 16'd0);
    chk("midrst_nwb", nwb, 16'd0);

    gen_program();
    ack_mode = 2;
    stub_on  = 1'b1;
    mon_on   = 1'b1;
    rst      = 1'b0;

    cyc = 0;
    while (evq.size() != 0 && cyc < 40000) begin
      @(posedge clk);
      cyc++;
    end
    mon_on   = 1'b0;
    stub_on  = 1'b0;
    ack_mode = 0;
    chk("drain", 16'(evq.size()), 16'd0);
    repeat (2) @(posedge clk);
    chk("slots_used", 16'(slot_idx), 16'(slots.size()));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
